// File: rtl/audio_seq_pkg.sv
// Shared types and constants for the audio playback/record sequencer.
package audio_seq_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam logic [ADDR_W-1:0] MAX_ADDR_DEF = 20'hFFFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REC   = 3'd1,
    S_START = 3'd2,
    S_PRIME = 3'd3,
    S_PLAY  = 3'd4,
    S_PAUSE = 3'd5
  } seq_state_t;

endpackage

// File: rtl/lrck_edge_det.sv
// LR-clock synchroniser with a registered single-cycle edge pulse.
module lrck_edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lrck,
  output logic o_tick
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_tick;
  logic w_edge;

  // Edge of the synchronised level in the selected direction
  always_comb begin
    w_edge = RISING ? (r_sync2 & ~r_prev) : (~r_sync2 & r_prev);
  end

  // Two-flop synchroniser, history flop and registered edge pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_lrck;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_tick  <= w_edge;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/audio_seq.sv
// Record/playback sequencer: key handling, sample counting and DSP strobes.
module audio_seq
  import audio_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_ADDR  = MAX_ADDR_DEF,
  parameter int unsigned       PRIME_CYC = 2
) (
  input  logic              i_BCLK,
  input  logic              i_rst,
  input  logic              i_key_record,
  input  logic              i_key_play,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic              i_ADCLRCK,
  input  logic              i_DACLRCK,
  input  logic              i_full,
  output logic              o_rec_start,
  output logic              o_rec_en,
  output logic              o_dsp_start,
  output logic              o_dsp_load,
  output logic              o_dsp_pop,
  output logic [ADDR_W-1:0] o_rec_len,
  output logic [2:0]        o_state,
  output logic              o_play_done
);

  localparam int unsigned PRIME_W = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYC - 1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [ADDR_W-1:0]   w_cnt_inc;
  logic [ADDR_W-1:0]   r_rec_len;
  logic [ADDR_W-1:0]   w_rec_len_nxt;
  logic [PRIME_W-1:0]  r_prime_cnt;
  logic [PRIME_W-1:0]  w_prime_nxt;
  logic                r_rec_start;
  logic                r_rec_en;
  logic                r_dsp_start;
  logic                r_dsp_load;
  logic                r_dsp_pop;
  logic                r_play_done;
  logic                w_rec_start_nxt;
  logic                w_rec_en_nxt;
  logic                w_dsp_start_nxt;
  logic                w_dsp_load_nxt;
  logic                w_dsp_pop_nxt;
  logic                w_play_done_nxt;
  logic                w_adc_tick;
  logic                w_dac_tick;

  lrck_edge_det #(.RISING(1'b1)) u_adc_edge (
    .i_clk  (i_BCLK),
    .i_rst  (i_rst),
    .i_lrck (i_ADCLRCK),
    .o_tick (w_adc_tick)
  );

  lrck_edge_det #(.RISING(1'b0)) u_dac_edge (
    .i_clk  (i_BCLK),
    .i_rst  (i_rst),
    .i_lrck (i_DACLRCK),
    .o_tick (w_dac_tick)
  );

  // Next-state, counter and strobe decode; stop outranks every other key
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rec_len_nxt   = r_rec_len;
    w_prime_nxt     = r_prime_cnt;
    w_rec_start_nxt = 1'b0;
    w_rec_en_nxt    = 1'b0;
    w_dsp_pop_nxt   = 1'b0;
    w_play_done_nxt = 1'b0;
    w_cnt_inc       = r_cnt + ADDR_W'(1);

    case (r_state)
      S_IDLE: begin
        if (i_key_record) begin
          w_state_nxt     = S_REC;
          w_rec_start_nxt = 1'b1;
          w_cnt_nxt       = '0;
        end else if (i_key_play && (r_rec_len != '0)) begin
          w_state_nxt = S_START;
        end
      end
      S_REC: begin
        if (w_adc_tick) begin
          w_rec_en_nxt = 1'b1;
          w_cnt_nxt    = w_cnt_inc;
        end
        if (i_key_stop || (w_adc_tick && (w_cnt_inc == MAX_ADDR))) begin
          w_state_nxt   = S_IDLE;
          w_rec_len_nxt = w_adc_tick ? w_cnt_inc : r_cnt;
        end
      end
      S_START: begin
        w_prime_nxt = '0;
        w_state_nxt = i_key_stop ? S_IDLE : S_PRIME;
      end
      S_PRIME: begin
        if (i_key_stop) begin
          w_state_nxt = S_IDLE;
        end else if (r_prime_cnt == PRIME_LAST) begin
          w_state_nxt = S_PLAY;
        end else begin
          w_prime_nxt = r_prime_cnt + PRIME_W'(1);
        end
      end
      S_PLAY: begin
        if (i_key_stop || i_full) begin
          w_state_nxt     = S_IDLE;
          w_play_done_nxt = 1'b1;
        end else if (i_key_pause) begin
          w_state_nxt = S_PAUSE;
        end else if (w_dac_tick) begin
          w_dsp_pop_nxt = 1'b1;
        end
      end
      S_PAUSE: begin
        if (i_key_stop || i_full) begin
          w_state_nxt     = S_IDLE;
          w_play_done_nxt = 1'b1;
        end else if (i_key_play || i_key_pause) begin
          w_state_nxt = S_PLAY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_dsp_start_nxt = (w_state_nxt == S_START);
    w_dsp_load_nxt  = (w_state_nxt == S_PRIME);
  end

  // State, counters and registered outputs
  always_ff @(posedge i_BCLK or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rec_len   <= '0;
      r_prime_cnt <= '0;
      r_rec_start <= 1'b0;
      r_rec_en    <= 1'b0;
      r_dsp_start <= 1'b0;
      r_dsp_load  <= 1'b0;
      r_dsp_pop   <= 1'b0;
      r_play_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rec_len   <= w_rec_len_nxt;
      r_prime_cnt <= w_prime_nxt;
      r_rec_start <= w_rec_start_nxt;
      r_rec_en    <= w_rec_en_nxt;
      r_dsp_start <= w_dsp_start_nxt;
      r_dsp_load  <= w_dsp_load_nxt;
      r_dsp_pop   <= w_dsp_pop_nxt;
      r_play_done <= w_play_done_nxt;
    end
  end

  assign o_rec_start = r_rec_start;
  assign o_rec_en    = r_rec_en;
  assign o_dsp_start = r_dsp_start;
  assign o_dsp_load  = r_dsp_load;
  assign o_dsp_pop   = r_dsp_pop;
  assign o_play_done = r_play_done;
  assign o_rec_len   = r_rec_len;
  assign o_state     = 3'(r_state);

endmodule

// File: tb/tb_audio_seq.sv
// Randomized bench for audio_seq against a cycle-level behavioural model.
module tb_audio_seq;

  localparam int MAX_A  = 7;
  localparam int PRIME  = 2;
  localparam int NCYC   = 5000;
  localparam int M_IDLE = 0, M_REC = 1, M_START = 2, M_PRIME = 3, M_PLAY = 4, M_PAUSE = 5;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_key_record, i_key_play, i_key_pause, i_key_stop;
  logic        i_ADCLRCK, i_DACLRCK, i_full;
  logic        o_rec_start, o_rec_en, o_dsp_start, o_dsp_load, o_dsp_pop, o_play_done;
  logic [19:0] o_rec_len;
  logic [2:0]  o_state;

  audio_seq #(.MAX_ADDR(20'd7), .PRIME_CYC(2)) dut (
    .i_BCLK      (clk),
    .i_rst       (i_rst),
    .i_key_record(i_key_record),
    .i_key_play  (i_key_play),
    .i_key_pause (i_key_pause),
    .i_key_stop  (i_key_stop),
    .i_ADCLRCK   (i_ADCLRCK),
    .i_DACLRCK   (i_DACLRCK),
    .i_full      (i_full),
    .o_rec_start (o_rec_start),
    .o_rec_en    (o_rec_en),
    .o_dsp_start (o_dsp_start),
    .o_dsp_load  (o_dsp_load),
    .o_dsp_pop   (o_dsp_pop),
    .o_rec_len   (o_rec_len),
    .o_state     (o_state),
    .o_play_done (o_play_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Model state: LR level history (index 0 = newest sample) plus sequencer view
  bit [4:0] ah, dh;
  int m_state, m_cnt, m_len, m_prime;
  bit e_rec_start, e_rec_en, e_dsp_start, e_dsp_load, e_dsp_pop, e_play_done;
  int adc_left, dac_left;
  bit did_rst;
  int pops_seen, recs_seen, plays_seen;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
  endtask

  task automatic model_reset();
    ah = '0; dh = '0;
    m_state = M_IDLE; m_cnt = 0; m_len = 0; m_prime = 0;
    {e_rec_start, e_rec_en, e_dsp_start, e_dsp_load, e_dsp_pop, e_play_done} = '0;
  endtask

  // One clock of the reference: edges seen 3 samples late, then key rules
  task automatic model_step();
    bit adc_t, dac_t, ks;
    ah = {ah[3:0], i_ADCLRCK};
    dh = {dh[3:0], i_DACLRCK};
    adc_t = ah[3] & ~ah[4];
    dac_t = ~dh[3] & dh[4];
    ks = i_key_stop;
    {e_rec_start, e_rec_en, e_dsp_pop, e_play_done} = '0;
    case (m_state)
      M_IDLE:
        if (i_key_record) begin m_state = M_REC; e_rec_start = 1; m_cnt = 0; end
        else if (i_key_play && m_len > 0) m_state = M_START;
      M_REC: begin
        if (adc_t) begin e_rec_en = 1; m_cnt++; end
        if (ks || (adc_t && m_cnt == MAX_A)) begin m_len = m_cnt; m_state = M_IDLE; end
      end
      M_START: begin m_prime = 0; m_state = ks ? M_IDLE : M_PRIME; end
      M_PRIME:
        if (ks) m_state = M_IDLE;
        else begin m_prime++; if (m_prime == PRIME) m_state = M_PLAY; end
      M_PLAY:
        if (ks || i_full) begin m_state = M_IDLE; e_play_done = 1; end
        else if (i_key_pause) m_state = M_PAUSE;
        else if (dac_t) e_dsp_pop = 1;
      M_PAUSE:
        if (ks || i_full) begin m_state = M_IDLE; e_play_done = 1; end
        else if (i_key_play || i_key_pause) m_state = M_PLAY;
      default: m_state = M_IDLE;
    endcase
    e_dsp_start = (m_state == M_START);
    e_dsp_load  = (m_state == M_PRIME);
  endtask

  task automatic compare_all();
    check("state",     int'(o_state),     m_state);
    check("rec_len",   int'(o_rec_len),   m_len);
    check("rec_start", int'(o_rec_start), int'(e_rec_start));
    check("rec_en",    int'(o_rec_en),    int'(e_rec_en));
    check("dsp_start", int'(o_dsp_start), int'(e_dsp_start));
    check("dsp_load",  int'(o_dsp_load),  int'(e_dsp_load));
    check("dsp_pop",   int'(o_dsp_pop),   int'(e_dsp_pop));
    check("play_done", int'(o_play_done), int'(e_play_done));
    if (o_dsp_pop) pops_seen++;
    if (o_rec_en) recs_seen++;
    if (o_state == 3'd4) plays_seen++;
  endtask

  task automatic drive_random();
    i_key_record = ($urandom_range(0, 24) == 0);
    i_key_play   = ($urandom_range(0, 11) == 0);
    i_key_pause  = ($urandom_range(0, 19) == 0);
    i_key_stop   = ($urandom_range(0, 59) == 0);
    i_full       = ($urandom_range(0, 49) == 0);
    if (adc_left == 0) begin i_ADCLRCK = ~i_ADCLRCK; adc_left = $urandom_range(2, 6); end
    else adc_left--;
    if (dac_left == 0) begin i_DACLRCK = ~i_DACLRCK; dac_left = $urandom_range(2, 6); end
    else dac_left--;
  endtask

  initial begin
    i_rst = 1'b1;
    {i_key_record, i_key_play, i_key_pause, i_key_stop, i_full} = '0;
    i_ADCLRCK = 1'b0; i_DACLRCK = 1'b0;
    adc_left = 3; dac_left = 4;
    did_rst = 0; pops_seen = 0; recs_seen = 0; plays_seen = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    // Play with nothing recorded must be ignored
    i_rst = 1'b0;
    i_key_play = 1'b1;
    @(posedge clk); model_step();
    @(negedge clk);
    i_key_play = 1'b0;
    check("play_empty_state", int'(o_state), 0);
    check("play_empty_start", int'(o_dsp_start), 0);

    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      compare_all();
      if (!did_rst && m_state == M_PLAY && c > 300) begin
        {i_key_record, i_key_play, i_key_pause, i_key_stop, i_full} = '0;
        i_rst = 1'b1;
        #1;
        check("rst_state", int'(o_state), 0);
        check("rst_strobes", int'({o_rec_start, o_rec_en, o_dsp_start,
                                   o_dsp_load, o_dsp_pop, o_play_done}), 0);
        check("rst_len", int'(o_rec_len), 0);
        model_reset();
        did_rst = 1;
      end else begin
        i_rst = 1'b0;
        drive_random();
      end
      @(posedge clk);
      if (!i_rst) model_step();
      @(negedge clk);
    end

    check("mid_play_reset_done", int'(did_rst), 1);
    check("pops_observed", int'(pops_seen > 0), 1);
    check("rec_en_observed", int'(recs_seen > 0), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
